// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit
//   Instruction-fetch stage. Holds the PC, issues sequential requests to
//   instruction memory, buffers in-order responses in a small prefetch FIFO
//   and presents one instruction per cycle in the IF/ID register.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   imem_req_valid/ready, imem_addr   request channel (addr == PC register)
//   imem_rsp_valid/data               in-order responses, >=1 cycle latency
//   redirect_valid/pc                 taken branch/jump, highest priority
//   stall_d                           Decode hold; IF/ID keeps its contents
//   InstrD, PCD, PCPlus4D, instr_valid_d   IF/ID register
module fetch_prefetch_unit #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall_d,
  output logic [DATA_W-1:0] InstrD,
  output logic [ADDR_W-1:0] PCD,
  output logic [ADDR_W-1:0] PCPlus4D,
  output logic              instr_valid_d
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;
  localparam logic [SW-1:0] DEPTH_C = SW'(FIFO_DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } fent_t;

  logic [ADDR_W-1:0] pc_q, pc_d;

  // prefetch FIFO
  fent_t             fifo_q [FIFO_DEPTH];
  logic [PW-1:0]     f_rd_q, f_wr_q;
  logic [CW-1:0]     f_cnt_q, f_cnt_d;

  // PCs of accepted-but-unanswered requests, oldest at iq_rd_q
  logic [ADDR_W-1:0] iq_q [FIFO_DEPTH];
  logic [PW-1:0]     iq_rd_q, iq_wr_q;
  logic [CW-1:0]     infl_q, infl_d;
  logic [CW-1:0]     drop_q, drop_d;

  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] pcd_q, pcp4_q;
  logic              ivld_q;

  logic [SW-1:0]     credit_used;
  logic              accept, rsp_ok, push, pop;
  fent_t             head;

  // Every FIFO slot is either filled or reserved by an in-flight request,
  // so responses can never overflow the FIFO.
  assign credit_used    = SW'(f_cnt_q) + SW'(infl_q);
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < DEPTH_C);
  assign imem_addr      = pc_q;

  assign accept = imem_req_valid && imem_req_ready;
  // A response with nothing in flight is a protocol error and is ignored.
  assign rsp_ok = imem_rsp_valid && (infl_q != '0);
  // Wrong-path responses (drop_q) and anything landing on a redirect edge
  // never reach the FIFO.
  assign push   = rsp_ok && (drop_q == '0) && !redirect_valid;
  assign pop    = !redirect_valid && !stall_d && (f_cnt_q != '0);
  assign head   = fifo_q[f_rd_q];

  always_comb begin
    pc_d    = accept ? pc_q + ADDR_W'(4) : pc_q;
    infl_d  = infl_q + CW'(accept) - CW'(rsp_ok);
    f_cnt_d = f_cnt_q + CW'(push) - CW'(pop);
    drop_d  = drop_q;
    if (rsp_ok && drop_q != '0) drop_d = drop_q - CW'(1);
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      f_cnt_d = '0;
      // no request can be accepted on a redirect edge, so everything still
      // in flight after this edge belongs to the wrong path
      drop_d  = infl_q - CW'(rsp_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      f_rd_q  <= '0;
      f_wr_q  <= '0;
      f_cnt_q <= '0;
      iq_rd_q <= '0;
      iq_wr_q <= '0;
      infl_q  <= '0;
      drop_q  <= '0;
      instr_q <= '0;
      pcd_q   <= '0;
      pcp4_q  <= '0;
      ivld_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      infl_q  <= infl_d;
      drop_q  <= drop_d;
      f_cnt_q <= f_cnt_d;
      if (accept) iq_wr_q <= iq_wr_q + PW'(1);
      if (rsp_ok) iq_rd_q <= iq_rd_q + PW'(1);
      if (push)   f_wr_q  <= f_wr_q + PW'(1);
      if (redirect_valid)  f_rd_q <= f_wr_q;
      else if (pop)        f_rd_q <= f_rd_q + PW'(1);

      if (redirect_valid) begin
        ivld_q <= 1'b0;
      end else if (!stall_d) begin
        ivld_q <= pop;
        if (pop) begin
          instr_q <= head.instr;
          pcd_q   <= head.pc;
          pcp4_q  <= head.pc + ADDR_W'(4);
        end
      end
    end
  end

  // storage arrays carry no reset; pointers/counts define what is live
  always_ff @(posedge clk) begin
    if (push)   fifo_q[f_wr_q] <= '{instr: imem_rsp_data, pc: iq_q[iq_rd_q]};
    if (accept) iq_q[iq_wr_q]  <= pc_q;
  end

  assign InstrD        = instr_q;
  assign PCD           = pcd_q;
  assign PCPlus4D      = pcp4_q;
  assign instr_valid_d = ivld_q;

endmodule
